rf_dbg_scanner: RTL and testbench
=================================

// Module: rf_dbg_scanner
// PURPOSE
//   Reader-side master for the register file's debug read port (dbg_reg_ra/dbg_reg_rd).
//   On a start pulse, walks register indices 0..NUM_REGS-1 and reads each one through the debug port.
//   Streams each {index, value} pair out on a valid/ready interface.
//   Feeds the simulation framework's state-dump / commit-compare path without touching the CPU datapath.
// PARAMETERS
//   NUM_REGS  32  registers scanned per pass; must be <= 2**ADDR_W
//   ADDR_W    5   register index width
//   DATA_W    32  register value width
// PORTS
//   clk          in   1       clock, rising-edge
//   rstn         in   1       asynchronous reset, active low
//   start        in   1       one-cycle scan request; honoured only in IDLE
//   abort        in   1       synchronous cancel of the current scan
//   dbg_reg_ra   out  ADDR_W  debug read address to the register file (registered)
//   dbg_reg_rd   in   DATA_W  debug read data; combinational from dbg_reg_ra
//   out_valid    out  1       out_idx/out_data valid
//   out_ready    in   1       consumer accepts when out_valid && out_ready
//   out_idx      out  ADDR_W  register index of the current beat
//   out_data     out  DATA_W  register value of the current beat
//   out_last     out  1       current beat is the final beat of this pass
//   busy         out  1       high in every state except IDLE
//   done         out  1       one-cycle pulse when a pass completes (not on abort)
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE, dbg_reg_ra=0, out_valid=0, out_idx=0, out_data=0,
//     out_last=0, busy=0, done=0, idx=0.
//   States: IDLE -> READ -> EMIT -> (READ | DONE) -> IDLE.
//   IDLE: if start: idx<=0, dbg_reg_ra<=0, go READ. Otherwise hold.
//   READ (1 cycle): dbg_reg_rd is valid for the registered dbg_reg_ra.
//     Capture out_data<=dbg_reg_rd and out_idx<=idx.
//     Set out_last<=(idx==NUM_REGS-1) and out_valid<=1, then go EMIT.
//   EMIT: hold out_valid and all out_* stable until out_ready.
//     On handshake with idx==NUM_REGS-1: out_valid<=0, go DONE.
//     On handshake otherwise: idx<=idx+1, dbg_reg_ra<=idx+1, out_valid<=0, go READ.
//   DONE (1 cycle): done=1, out_last<=0, idx<=0, go IDLE.
//   Latency: start at cycle T gives out_valid at T+2. With out_ready tied high, each beat takes
//     2 cycles, so a full pass takes 2*NUM_REGS cycles plus the DONE cycle.
//   Index 0 is read like any other; the register file returns its own value (0).
//   start while busy: ignored, with no queueing.
//   abort (any non-IDLE state): next cycle state=IDLE, out_valid=0, out_last=0, idx=0, no done.
//     abort has priority over the out_ready handshake in the same cycle.
//     abort and start together in IDLE: start wins.
//   Values are sampled per register at its READ cycle; the pass is not an atomic snapshot.
//     A register-file write landing between beats is visible in later beats only.
//   idx arithmetic is ADDR_W wide and never wraps past NUM_REGS-1.
// CONFIGURATION
//   RF_SCAN_DIFF_EN defined: keep a NUM_REGS x DATA_W shadow copy, cleared to 0 at reset.
//     In READ, if dbg_reg_rd == shadow[idx] and idx != NUM_REGS-1, emit nothing:
//     advance idx and stay in READ.
//     Otherwise emit the beat and update shadow[idx] on handshake.
//     The last index always emits so out_last still terminates the pass.
//     An aborted pass leaves already-updated shadow entries updated.
//   RF_SCAN_DIFF_EN undefined: every register emits every pass; no shadow storage.
// TESTING
//   1. Preload x1=0x12345678, x31=0xDEADBEEF, others 0; start, out_ready=1
//      -> 32 beats idx 0..31, beat1 data 0x12345678, beat31 data 0xDEADBEEF with out_last=1,
//      done pulses exactly once at cycle T+65.
//   2. Random out_ready backpressure (~50%)
//      -> out_* stable while valid && !ready; beat order and data unchanged; no beat lost or duplicated.
//   3. start pulsed again at beat 10
//      -> ignored; pass completes with 32 beats and a single done.
//   4. abort during EMIT of idx 7 with out_ready=1 same cycle
//      -> no handshake counted; next cycle IDLE, busy=0, out_valid=0, done never pulses.
//   5. rstn low during READ of idx 20
//      -> all outputs at reset values immediately; a fresh start restarts from idx 0.
//   6. RF_SCAN_DIFF_EN: two passes, write x5=0xA5A5A5A5 between them
//      -> second pass emits idx 5 and idx 31 (out_last=1) only.

Source files
------------

// File: rtl/rf_dbg_scanner.sv
// rf_dbg_scanner: debug-port master that walks the register file and
// streams {index, value} beats on a valid/ready interface for the
// simulation framework's state-dump / commit-compare path.
//
// Optional feature macro: RF_SCAN_DIFF_EN
//   When defined, a shadow copy of the last emitted value of every register
//   is kept and unchanged registers are skipped. The final index always
//   emits so out_last still closes every pass.
module rf_dbg_scanner #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] dbg_reg_ra,
  input  logic [DATA_W-1:0] dbg_reg_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] ra_n;
  logic [ADDR_W-1:0] out_idx_n;
  logic [DATA_W-1:0] out_data_n;
  logic              out_valid_n;
  logic              out_last_n;

  logic              idx_is_last;
  logic              handshake;
  logic [ADDR_W-1:0] idx_inc;

  // idx never advances past LAST_IDX, so the increment cannot wrap
  assign idx_is_last = (idx == LAST_IDX);
  assign handshake   = out_valid && out_ready;
  assign idx_inc     = idx + IDX_ONE;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef RF_SCAN_DIFF_EN
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic              rd_unchanged;
  logic              shadow_we;

  // Skip only non-final registers whose value matches what was last emitted
  assign rd_unchanged = (dbg_reg_rd == shadow[idx]) && !idx_is_last;
  // Shadow follows accepted beats only, so an abort never records an unsent value
  assign shadow_we    = (state == S_EMIT) && handshake && !abort;
`endif

  // Next-state and next-register computation; every target holds by default
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    ra_n        = dbg_reg_ra;
    out_idx_n   = out_idx;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_last_n  = out_last;

    if (abort && (state != S_IDLE)) begin
      // Cancel beats the handshake: the beat on the bus is dropped, no done
      state_n     = S_IDLE;
      idx_n       = '0;
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx_n   = '0;
            ra_n    = '0;
            state_n = S_READ;
          end
        end

        S_READ: begin
`ifdef RF_SCAN_DIFF_EN
          if (rd_unchanged) begin
            idx_n = idx_inc;
            ra_n  = idx_inc;
          end else begin
`else
          begin
`endif
            // Read data is combinational from the registered address
            out_data_n  = dbg_reg_rd;
            out_idx_n   = idx;
            out_last_n  = idx_is_last;
            out_valid_n = 1'b1;
            state_n     = S_EMIT;
          end
        end

        S_EMIT: begin
          if (handshake) begin
            out_valid_n = 1'b0;
            if (idx_is_last) begin
              state_n = S_DONE;
            end else begin
              idx_n   = idx_inc;
              ra_n    = idx_inc;
              state_n = S_READ;
            end
          end
        end

        S_DONE: begin
          out_last_n = 1'b0;
          idx_n      = '0;
          state_n    = S_IDLE;
        end

        default: begin
          state_n     = S_IDLE;
          idx_n       = '0;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      idx        <= '0;
      dbg_reg_ra <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dbg_reg_ra <= ra_n;
      out_valid  <= out_valid_n;
      out_idx    <= out_idx_n;
      out_data   <= out_data_n;
      out_last   <= out_last_n;
    end
  end

`ifdef RF_SCAN_DIFF_EN
  // Shadow copy of last emitted values, cleared to zero at reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow[out_idx] <= out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rf_dbg_scanner.sv
// Directed bench for rf_dbg_scanner with a register-file model and a
// scoreboard of expected beats. Follows RF_SCAN_DIFF_EN like the RTL.
module tb_rf_dbg_scanner;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef RF_SCAN_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] dbg_reg_ra;
  logic [DATA_W-1:0] dbg_reg_rd;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf       [NUM_REGS];
  logic [DATA_W-1:0] shadow_m [NUM_REGS];

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sb[$];

  int total = 0;
  int bad   = 0;
  int n_beats, n_done, done_cyc, first_valid_cyc, exp_beats;

  always #5 clk = ~clk;

  assign dbg_reg_rd = rf[dbg_reg_ra];

  rf_dbg_scanner #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .dbg_reg_ra(dbg_reg_ra),
    .dbg_reg_rd(dbg_reg_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ra"},    64'(dbg_reg_ra), 64'd0);
    check({tag, "_valid"}, 64'(out_valid),  64'd0);
    check({tag, "_idx"},   64'(out_idx),    64'd0);
    check({tag, "_data"},  64'(out_data),   64'd0);
    check({tag, "_last"},  64'(out_last),   64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
  endtask

  // Expected beats of one complete pass, from the model and its shadow copy
  task automatic push_pass();
    beat_t b;
    sb.delete();
    exp_beats = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!DIFF || (rf[i] !== shadow_m[i]) || (i == NUM_REGS - 1)) begin
        b.idx  = ADDR_W'(i);
        b.data = rf[i];
        b.last = (i == NUM_REGS - 1);
        sb.push_back(b);
        exp_beats++;
      end
    end
  endtask

  task automatic fill_rf(input int seed);
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i] = {8'(seed), 16'hC0DE, 8'(i)};
    end
  endtask

  // One pass: optional random backpressure, restart pulse at a beat count,
  // abort at a given index, or reset during the READ after a given index
  task automatic scan(input bit rnd, input int restart_beat, input int abort_idx,
                      input int rst_after_idx, input int max_cyc);
    int    cyc;
    bit    fin, hold, pend_rst, aborted, restarted;
    beat_t held, e;
    n_beats = 0; n_done = 0; done_cyc = -1; first_valid_cyc = -1;
    push_pass();
    @(negedge clk);
    start = 1'b1;
    cyc = 0; fin = 0; hold = 0; pend_rst = 0; aborted = 0; restarted = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (pend_rst) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        fin = 1;
      end else if (aborted) begin
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_last",  64'(out_last),  64'd0);
        repeat (4) begin
          if (done) n_done++;
          @(negedge clk);
        end
        fin = 1;
      end else if (cyc > max_cyc) begin
        check("timeout_cycles", 64'(cyc), 64'(max_cyc));
        fin = 1;
      end else begin
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_beat",  64'({out_idx, out_data, out_last}), 64'(held));
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
          check("done_valid", 64'(out_valid), 64'd0);
          check("done_sb_empty", 64'(sb.size()), 64'd0);
          fin = 1;
        end
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && !restarted && restart_beat >= 0 && n_beats == restart_beat) begin
          start = 1'b1;
          restarted = 1;
        end
        if (out_valid && abort_idx >= 0 && int'(out_idx) == abort_idx) begin
          abort     = 1'b1;
          out_ready = 1'b1;
          aborted   = 1;
        end else if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("extra_beat_idx", 64'(out_idx), 64'hFFFF);
          end else begin
            e = sb.pop_front();
            check("beat_idx",  64'(out_idx),  64'(e.idx));
            check("beat_data", 64'(out_data), 64'(e.data));
            check("beat_last", 64'(out_last), 64'(e.last));
            shadow_m[e.idx] = e.data;
          end
          n_beats++;
          if (rst_after_idx >= 0 && int'(out_idx) == rst_after_idx) pend_rst = 1;
        end
        hold = out_valid && !out_ready;
        held = '{idx: out_idx, data: out_data, last: out_last};
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i] = '0;
      shadow_m[i] = '0;
    end
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Full pass with sparse contents, consumer always ready
    rf[1]  = 32'h1234_5678;
    rf[31] = 32'hDEAD_BEEF;
    scan(1'b0, -1, -1, -1, 200);
    check("t1_beats", 64'(n_beats), 64'(exp_beats));
    check("t1_done",  64'(n_done),  64'd1);
    if (!DIFF) begin
      check("t1_first_valid", 64'(first_valid_cyc), 64'd2);
      check("t1_done_cyc",    64'(done_cyc),        64'd65);
    end
    @(negedge clk);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_last", 64'(out_last), 64'd0);

    // Random backpressure
    for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
    scan(1'b1, -1, -1, -1, 1000);
    check("t2_beats", 64'(n_beats), 64'(exp_beats));
    check("t2_done",  64'(n_done),  64'd1);

    // start repeated mid-pass is ignored
    fill_rf(3);
    scan(1'b0, 10, -1, -1, 200);
    check("t3_beats", 64'(n_beats), 64'(exp_beats));
    check("t3_done",  64'(n_done),  64'd1);
    @(negedge clk);
    check("t3_busy_after", 64'(busy), 64'd0);

    // abort while idx 7 is offered with ready high
    fill_rf(4);
    scan(1'b0, -1, 7, -1, 200);
    check("t4_beats", 64'(n_beats), 64'd7);
    check("t4_done",  64'(n_done),  64'd0);

    // reset during the READ of idx 20, then a fresh pass from idx 0
    fill_rf(5);
    scan(1'b0, -1, -1, 19, 200);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) shadow_m[i] = '0;
    @(negedge clk);
    scan(1'b0, -1, -1, -1, 200);
    check("t5_beats", 64'(n_beats), 64'(exp_beats));
    check("t5_done",  64'(n_done),  64'd1);

`ifdef RF_SCAN_DIFF_EN
    // Second pass after a single write only reports the change and the last index
    fill_rf(6);
    scan(1'b0, -1, -1, -1, 200);
    rf[5] = 32'hA5A5_A5A5;
    scan(1'b0, -1, -1, -1, 200);
    check("t6_beats", 64'(n_beats), 64'd2);
    check("t6_done",  64'(n_done),  64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
